// File: rtl/frank_control_unit.sv
// frank_control_unit: FRANK6000 main sequencer. Decodes the 4-bit opcode into
// datapath mux selects and write strobes using a FETCH / CYCLE1 / IDLE(CYCLE2)
// state machine. All control outputs are Mealy-decoded from (state, opcode).
// Optional feature macro: CU_DEBUG_STATE_EN exposes the state register as o_state.

`define NOP     4'h0
`define JMP     4'h1
`define JCOND   4'h2
`define R2_FLR  4'h3
`define ALU_WI  4'h4
`define LD_W    4'h5
`define ST_F    4'h6
`define LD_ADDR 4'h7
`define RET     4'h9
`define CALLS   4'hC

module frank_control_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_control_input,
  output logic       o_jump,
  output logic [1:0] o_j_mode,
  output logic       o_call,
  output logic       o_return,
  output logic       o_ADDRin,
  output logic       o_FRin,
  output logic [1:0] o_WREGin,
  output logic       o_ALUin1,
  output logic       o_ALUin2,
  output logic       o_PCw,
  output logic       o_ADDRw,
  output logic       o_FRw,
  output logic       o_WREGw,
  output logic       o_STATUSw
`ifdef CU_DEBUG_STATE_EN
  ,
  output logic [1:0] o_state
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_CYCLE1 = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  state_t      r_state;
  logic [15:0] w_v_fetch;
  logic [15:0] w_v_cycle1;
  logic        w_long;
  logic [15:0] w_v;

  // Opcode decode: control vector for FETCH, for CYCLE1, and whether the
  // instruction needs the extra IDLE/CYCLE2 slot after CYCLE1.
  always_comb begin
    w_v_fetch  = 16'h0010;
    w_v_cycle1 = 16'h0000;
    w_long     = 1'b0;
    case (i_control_input)
      `JMP:     w_v_fetch = 16'h8010;
      `JCOND:   w_v_fetch = 16'hC010;
      `RET:     w_v_fetch = 16'h0810;
      `CALLS:   w_v_fetch = 16'hB010;
      `R2_FLR: begin
        w_v_fetch  = 16'h0000;
        w_v_cycle1 = 16'h0033;
        w_long     = 1'b1;
      end
      `ALU_WI: begin
        w_v_fetch  = 16'h0000;
        w_v_cycle1 = 16'h0053;
        w_long     = 1'b1;
      end
      `LD_W: begin
        w_v_fetch  = 16'h0000;
        w_v_cycle1 = 16'h0092;
        w_long     = 1'b1;
      end
      `ST_F: begin
        w_v_fetch  = 16'h0000;
        w_v_cycle1 = 16'h0014;
        w_long     = 1'b1;
      end
      `LD_ADDR: begin
        w_v_fetch  = 16'h0000;
        w_v_cycle1 = 16'h0018;
        w_long     = 1'b1;
      end
      default: ;
    endcase
  end

  // State sequencing; holds whenever the sequencer is disabled.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_state <= S_IDLE;
    else if (i_en)
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_CYCLE1;
        S_CYCLE1: r_state <= w_long ? S_IDLE : S_FETCH;
        default:  r_state <= S_IDLE;
      endcase
  end

  // Output select: disabled, reset, IDLE and the unused state all drive zero.
  always_comb begin
    w_v = (!i_rst || !i_en)      ? 16'h0000   :
          (r_state == S_FETCH)   ? w_v_fetch  :
          (r_state == S_CYCLE1)  ? w_v_cycle1 : 16'h0000;
  end

  assign o_jump    = w_v[15];
  assign o_j_mode  = w_v[14:13];
  assign o_call    = w_v[12];
  assign o_return  = w_v[11];
  assign o_ADDRin  = w_v[10];
  assign o_FRin    = w_v[9];
  assign o_WREGin  = w_v[8:7];
  assign o_ALUin1  = w_v[6];
  assign o_ALUin2  = w_v[5];
  assign o_PCw     = w_v[4];
  assign o_ADDRw   = w_v[3];
  assign o_FRw     = w_v[2];
  assign o_WREGw   = w_v[1];
  assign o_STATUSw = w_v[0];

`ifdef CU_DEBUG_STATE_EN
  assign o_state = r_state;
`endif

endmodule

// File: tb/tb_frank_control_unit.sv
// tb_frank_control_unit: directed checks plus a per-cycle reference model of the sequencer.
module tb_frank_control_unit;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_en = 1'b0;
  logic [3:0] i_control_input = 4'h0;
  logic       o_jump, o_call, o_return, o_ADDRin, o_FRin, o_ALUin1, o_ALUin2;
  logic       o_PCw, o_ADDRw, o_FRw, o_WREGw, o_STATUSw;
  logic [1:0] o_j_mode, o_WREGin;
`ifdef CU_DEBUG_STATE_EN
  logic [1:0] o_state;
`endif
  logic [15:0] w_v;

  int n_cmp = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  frank_control_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_control_input(i_control_input),
    .o_jump(o_jump), .o_j_mode(o_j_mode), .o_call(o_call), .o_return(o_return),
    .o_ADDRin(o_ADDRin), .o_FRin(o_FRin), .o_WREGin(o_WREGin), .o_ALUin1(o_ALUin1),
    .o_ALUin2(o_ALUin2), .o_PCw(o_PCw), .o_ADDRw(o_ADDRw), .o_FRw(o_FRw),
    .o_WREGw(o_WREGw), .o_STATUSw(o_STATUSw)
`ifdef CU_DEBUG_STATE_EN
    , .o_state(o_state)
`endif
  );

  assign w_v = {o_jump, o_j_mode, o_call, o_return, o_ADDRin, o_FRin, o_WREGin,
                o_ALUin1, o_ALUin2, o_PCw, o_ADDRw, o_FRw, o_WREGw, o_STATUSw};

  always #5 i_clk = ~i_clk;

  // Reference tables: first-step vector, second-step vector, and whether the
  // instruction is followed by an extra quiet step.
  logic [15:0] m_first [16];
  logic [15:0] m_second[16];
  bit          m_long  [16];
  // Model position: 0 = quiet step, 1 = first step of instruction, 2 = second step.
  int          m_step = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_first[i] = 16'h0010; m_second[i] = 16'h0000; m_long[i] = 1'b0;
    end
    m_first[1] = 16'h8010; m_first[2] = 16'hC010; m_first[9] = 16'h0810; m_first[12] = 16'hB010;
    m_first[3] = 16'h0; m_second[3] = 16'h0033; m_long[3] = 1'b1;
    m_first[4] = 16'h0; m_second[4] = 16'h0053; m_long[4] = 1'b1;
    m_first[5] = 16'h0; m_second[5] = 16'h0092; m_long[5] = 1'b1;
    m_first[6] = 16'h0; m_second[6] = 16'h0014; m_long[6] = 1'b1;
    m_first[7] = 16'h0; m_second[7] = 16'h0018; m_long[7] = 1'b1;
  end

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) m_step <= 0;
    else if (i_en) m_step <= (m_step == 1) ? 2 : (m_step == 2 && !m_long[i_control_input]) ? 1 : (m_step == 2) ? 0 : 1;
  end

  function automatic logic [15:0] model_v();
    if (!i_rst || !i_en) return 16'h0;
    return (m_step == 1) ? m_first[i_control_input] : (m_step == 2) ? m_second[i_control_input] : 16'h0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (run_cmp) begin
      chk($sformatf("model_v op=%h step=%0d", i_control_input, m_step), w_v, model_v());
`ifdef CU_DEBUG_STATE_EN
      chk("model_state", {14'h0, o_state}, 16'(m_step));
`endif
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    #3 i_rst = 1'b1;
    #1 chk("reset_v", w_v, 16'h0000);
    i_en = 1'b1; i_control_input = 4'hC;
    run_cmp = 1'b1;
    step(); #1 chk("calls_fetch", w_v, 16'hB010);
    step(); #1 chk("calls_cycle1", w_v, 16'h0000);
    step(); i_control_input = 4'h3; #1 chk("r2flr_fetch", w_v, 16'h0000);
    step(); #1 chk("r2flr_cycle1", w_v, 16'h0033);
    step(); #1 chk("r2flr_idle", w_v, 16'h0000);
    step(); #1 chk("r2flr_refetch", w_v, 16'h0000);
    step(); #1 chk("r2flr_cycle1b", w_v, 16'h0033);
    i_en = 1'b0; #1 chk("en_low_v", w_v, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step(); #1 chk("en_low_hold", w_v, 16'h0000);
    end
    i_en = 1'b1; #1 chk("en_resume_cycle1", w_v, 16'h0033);
    step(); #1 chk("resume_idle", w_v, 16'h0000);
    i_control_input = 4'h4;
    step(); step(); #1 chk("aluwi_cycle1", w_v, 16'h0053);
    i_rst = 1'b0; #1 chk("async_reset_v", w_v, 16'h0000);
    #1 i_rst = 1'b1;
    // Opcode sweep: each opcode held for four steps from a quiet start.
    for (int op = 0; op < 16; op++) begin
      i_control_input = 4'(op);
      for (int k = 0; k < 4; k++) step();
      @(negedge i_clk);
      i_rst = 1'b0; #1 i_rst = 1'b1;
    end
    // Opcode changes between states and random enable gaps.
    for (int k = 0; k < 60; k++) begin
      step();
      i_control_input = 4'($urandom_range(0, 15));
      i_en = ($urandom_range(0, 3) != 0);
    end
    step();
    i_en = 1'b1;
    i_control_input = 4'h9;
    step(); step(); step();
    @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
